conv_window_mac: RTL and testbench

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_clamp.sv | 31 +++
 rtl/conv_window_mac.sv | 127 ++++++++++++
 tb/tb_conv_window_mac.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, window constants and FSM encoding for the 3x3 convolution MAC.
package conv_pkg;

    localparam int PIX_W       = 12;
    localparam int COEF_W      = 8;
    localparam int PROD_W      = 21;
    localparam int ACC_W       = 25;
    localparam int ADDR_W      = 17;
    localparam int IDX_W       = 4;
    localparam int TAPS        = 9;
    localparam int DEF_NO_ROWS = 5;
    localparam int DEF_NO_COLS = 5;
    localparam int PIX_MAX     = (1 << PIX_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/conv_clamp.sv
// Arithmetic right shift of a window sum followed by saturation to the
// unsigned 12-bit pixel range.
module conv_clamp
    import conv_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic [ACC_W-1:0] sum,
    output logic [PIX_W-1:0] res
);

    localparam logic signed [ACC_W-1:0] PIX_MAX_S = ACC_W'(PIX_MAX);

    logic signed [ACC_W-1:0] shifted;

    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [ACC_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v[ACC_W-1]) begin
            r = '0;
        end else if (v > PIX_MAX_S) begin
            r = PIX_W'(PIX_MAX);
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

    assign shifted = $signed(sum) >>> SHIFT;
    assign res     = sat_pix(shifted);

endmodule

// File: rtl/conv_window_mac.sv
// 3x3 window multiply-accumulate: nine pixels per window against nine signed
// taps, one clamped result written per window, framed by an IDLE/RUN/DONE FSM.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int NO_ROWS = DEF_NO_ROWS,
    parameter int NO_COLS = DEF_NO_COLS,
    parameter int SHIFT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              coef_we,
    input  logic [IDX_W-1:0]  coef_idx,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  d_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [PIX_W-1:0]  d_out,
    output logic              busy,
    output logic              ready
);

    localparam int                NUM_WIN  = (NO_ROWS - 2) * (NO_COLS - 2);
    localparam logic [ADDR_W-1:0] LAST_WIN = ADDR_W'(NUM_WIN - 1);
    localparam logic [ADDR_W-1:0] END_WIN  = ADDR_W'(NUM_WIN);
    localparam logic [IDX_W-1:0]  LAST_TAP = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0]  NUM_TAPS = IDX_W'(TAPS);

    conv_state_t              state;
    conv_state_t              state_nxt;
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [IDX_W-1:0]         tap;
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        win_cnt;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  win_sum;
    logic [PIX_W-1:0]         clamp_res;
    logic                     accept;
    logic                     tap_last;
    logic                     coef_wr_ok;

    logic                     vld_p1;
    logic [PIX_W-1:0]         res_p1;
    logic [ADDR_W-1:0]        addr_p1;

    // Pixels are only consumed while windows remain, so stray valids after the
    // last capture cannot push the window counter past the frame.
    assign accept     = (state == ST_RUN) && in_valid && (win_cnt != END_WIN);
    assign tap_last   = (tap == LAST_TAP);
    assign coef_wr_ok = coef_we && (state != ST_RUN) && (coef_idx < NUM_TAPS);

    assign prod    = $signed({1'b0, d_in}) * coef[tap];
    assign win_sum = acc + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});

    conv_clamp #(
        .SHIFT (SHIFT)
    ) u_clamp (
        .sum (win_sum),
        .res (clamp_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (vld_p1 && (addr_p1 == LAST_WIN)) state_nxt = ST_DONE;
            ST_DONE: if (start) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: tap accumulation; the tap-8 edge captures the clamped sum into
    // p1 and restarts the accumulator so the next window needs no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap     <= '0;
            acc     <= '0;
            win_cnt <= '0;
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            addr_p1 <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else begin
            vld_p1 <= 1'b0;
            if (coef_wr_ok) begin
                coef[coef_idx] <= $signed(coef_in);
            end
            if ((state == ST_IDLE) && start) begin
                tap     <= '0;
                acc     <= '0;
                win_cnt <= '0;
            end else if (accept) begin
                if (tap_last) begin
                    tap     <= '0;
                    acc     <= '0;
                    win_cnt <= win_cnt + ADDR_W'(1);
                    vld_p1  <= 1'b1;
                    res_p1  <= clamp_res;
                    addr_p1 <= win_cnt;
                end else begin
                    tap <= tap + IDX_W'(1);
                    acc <= win_sum;
                end
            end
        end
    end

    // Stage p1: registered result drives the write port and holds between writes.
    assign wr_en   = vld_p1;
    assign d_out   = res_p1;
    assign addr_wr = addr_p1;
    assign busy    = (state == ST_RUN);
    assign ready   = (state == ST_DONE);

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed-plus-random bench for conv_window_mac: two instances (SHIFT=0 and
// SHIFT=4) share stimulus and are compared against a plain-arithmetic window model.
module tb_conv_window_mac;

    localparam int NWIN = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_idx = '0;
    logic [7:0]  coef_in = '0;
    logic        in_valid = 1'b0;
    logic [11:0] d_in = '0;

    logic        wr_en0, busy0, ready0;
    logic [16:0] addr_wr0;
    logic [11:0] d_out0;
    logic        wr_en4, busy4, ready4;
    logic [16:0] addr_wr4;
    logic [11:0] d_out4;

    conv_window_mac #(.NO_ROWS(5), .NO_COLS(5), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_in(coef_in), .in_valid(in_valid), .d_in(d_in), .wr_en(wr_en0),
        .addr_wr(addr_wr0), .d_out(d_out0), .busy(busy0), .ready(ready0)
    );

    conv_window_mac #(.NO_ROWS(5), .NO_COLS(5), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_in(coef_in), .in_valid(in_valid), .d_in(d_in), .wr_en(wr_en4),
        .addr_wr(addr_wr4), .d_out(d_out4), .busy(busy4), .ready(ready4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int dout;
        int cyc;
        int acc;
    } wr_t;

    wr_t q0[$];
    wr_t q4[$];
    int  cyc = 0;
    int  acc_cnt = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  pix [NWIN][9];
    int  coef_m [9];

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor; acc_cnt is the number of pixels accepted before this cycle.
    always @(negedge clk) begin
        if (wr_en0) q0.push_back('{int'(addr_wr0), int'(d_out0), cyc, acc_cnt});
        if (wr_en4) q4.push_back('{int'(addr_wr4), int'(d_out4), cyc, acc_cnt});
        if (in_valid && busy0) acc_cnt = acc_cnt + 1;
    end

    function automatic int model(input int w, input int sh);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s = s + pix[w][k] * coef_m[k];
        s = s >>> sh;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coefs();
        for (int k = 0; k < 9; k++) begin
            coef_we = 1'b1; coef_idx = 4'(k); coef_in = 8'(coef_m[k]);
            step();
        end
        coef_we = 1'b1; coef_idx = 4'd12; coef_in = 8'd99;
        step();
        coef_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_pix(input int p, input int gap_max, input bit we_run, input int k);
        in_valid = 1'b1;
        d_in = 12'(p);
        if (we_run) begin
            coef_we = 1'b1; coef_idx = 4'(k); coef_in = 8'h55;
        end
        step();
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 1)) begin
                d_in = 12'($urandom);
                step();
            end
        end
    endtask

    task automatic run_frame(input int gap_max, input bit we_run);
        q0.delete();
        q4.delete();
        acc_cnt = 0;
        pulse_start();
        for (int w = 0; w < NWIN; w++)
            for (int k = 0; k < 9; k++)
                send_pix(pix[w][k], gap_max, we_run, k);
        for (int i = 0; i < 20 && !ready0; i++) step();
        step();
    endtask

    task automatic check_frame(input string tag, input bit b2b);
        check({tag, "_nwr0"}, q0.size(), NWIN);
        check({tag, "_nwr4"}, q4.size(), NWIN);
        for (int n = 0; n < q0.size() && n < NWIN; n++) begin
            check($sformatf("%s_addr0_w%0d", tag, n), q0[n].addr, n);
            check($sformatf("%s_dout0_w%0d", tag, n), q0[n].dout, model(n, 0));
            check($sformatf("%s_lat_w%0d", tag, n), q0[n].acc, 9 * (n + 1));
            if (b2b && n > 0)
                check($sformatf("%s_gap_w%0d", tag, n), q0[n].cyc - q0[n-1].cyc, 9);
        end
        for (int n = 0; n < q4.size() && n < NWIN; n++) begin
            check($sformatf("%s_addr4_w%0d", tag, n), q4[n].addr, n);
            check($sformatf("%s_dout4_w%0d", tag, n), q4[n].dout, model(n, 4));
        end
        check({tag, "_hold_addr"}, addr_wr0, NWIN - 1);
        check({tag, "_hold_dout"}, d_out0, model(NWIN - 1, 0));
        check({tag, "_ready0"}, ready0, 1);
        check({tag, "_ready4"}, ready4, 1);
        check({tag, "_busy0"}, busy0, 0);
        check({tag, "_wr_idle"}, wr_en0, 0);
    endtask

    task automatic finish_frame(input string tag);
        pulse_start();
        check({tag, "_idle_ready"}, ready0, 0);
        check({tag, "_idle_busy"}, busy0, 0);
    endtask

    task automatic fill_const(input int c, input int p);
        for (int k = 0; k < 9; k++) coef_m[k] = c;
        for (int w = 0; w < NWIN; w++)
            for (int k = 0; k < 9; k++) pix[w][k] = p;
    endtask

    task automatic fill_rand_pix();
        for (int w = 0; w < NWIN; w++)
            for (int k = 0; k < 9; k++) pix[w][k] = int'($urandom_range(4095));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ready", ready0, 0);
        check("rst_addr", addr_wr0, 0);
        check("rst_dout", d_out0, 0);
        rst = 1'b0;
        step();

        // A: all-ones kernel, constant pixels, back-to-back
        fill_const(1, 100);
        load_coefs();
        run_frame(0, 1'b0);
        check("A_dout_900", q0.size() > 0 ? q0[0].dout : -1, 900);
        check_frame("A", 1'b1);
        finish_frame("A");

        // B: centre-tap-only kernel recovers the tap-4 pixel at SHIFT=4
        for (int k = 0; k < 9; k++) coef_m[k] = 0;
        coef_m[4] = 16;
        load_coefs();
        fill_rand_pix();
        for (int w = 0; w < NWIN; w++) pix[w][4] = 10 * w + 5;
        run_frame(0, 1'b0);
        for (int n = 0; n < q4.size() && n < NWIN; n++)
            check($sformatf("B_centre_w%0d", n), q4[n].dout, 10 * n + 5);
        check_frame("B", 1'b1);
        finish_frame("B");

        // C: negative sums clamp to zero
        fill_const(-1, 50);
        load_coefs();
        run_frame(0, 1'b0);
        check_frame("C", 1'b1);
        finish_frame("C");

        // D: large positive sums clamp to 4095
        fill_const(127, 4095);
        load_coefs();
        run_frame(0, 1'b0);
        check("D_dout_max", q0.size() > 0 ? q0[0].dout : -1, 4095);
        check_frame("D", 1'b1);
        finish_frame("D");

        // E: all-ones kernel with random 1..3 cycle gaps
        fill_const(1, 100);
        load_coefs();
        run_frame(3, 1'b0);
        check_frame("E", 1'b0);
        finish_frame("E");
        fill_rand_pix();
        run_frame(3, 1'b0);
        check_frame("E2", 1'b0);
        finish_frame("E2");

        // F: random signed kernel and random pixels
        for (int k = 0; k < 9; k++) coef_m[k] = int'($urandom_range(255)) - 128;
        load_coefs();
        fill_rand_pix();
        run_frame(0, 1'b0);
        check_frame("F", 1'b1);
        finish_frame("F");

        // G: coefficient writes while running are ignored
        for (int k = 0; k < 9; k++) coef_m[k] = 1;
        load_coefs();
        fill_rand_pix();
        run_frame(0, 1'b1);
        check_frame("G", 1'b1);
        finish_frame("G");

        // H: asynchronous reset at tap 5 of window 3
        fill_rand_pix();
        q0.delete();
        q4.delete();
        acc_cnt = 0;
        pulse_start();
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 9; k++) send_pix(pix[w][k], 0, 1'b0, k);
        for (int k = 0; k < 6; k++) send_pix(pix[3][k], 0, 1'b0, k);
        check("H_pre_addr", addr_wr0, 2);
        check("H_pre_busy", busy0, 1);
        #3 rst = 1'b1;
        #1;
        check("H_rst_wr_en", wr_en0, 0);
        check("H_rst_busy", busy0, 0);
        check("H_rst_ready", ready0, 0);
        check("H_rst_addr", addr_wr0, 0);
        check("H_rst_dout", d_out0, 0);
        check("H_rst_dout4", d_out4, 0);
        #2 rst = 1'b0;
        step();
        sz = q0.size();
        check("H_pre_writes", sz, 3);
        in_valid = 1'b1;
        repeat (12) begin
            d_in = 12'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("H_no_write", q0.size(), sz);
        check("H_idle_busy", busy0, 0);
        for (int k = 0; k < 9; k++) coef_m[k] = 0;
        fill_rand_pix();
        run_frame(0, 1'b0);
        check("H_w0_addr", q0.size() > 0 ? q0[0].addr : -1, 0);
        check("H_w0_dout", q0.size() > 0 ? q0[0].dout : -1, 0);
        check_frame("H", 1'b1);
        finish_frame("H");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
